fp_mul_pipe: RTL and testbench

Parametrised, stall-capable IEEE-754 binary floating-point multiplier for the FPU datapath, successor to the fixed single-precision pipelined multiplier. Width is generic over exponent/fraction size, operands travel with a valid/ready handshake, results are rounded to nearest-even, and special operands (zero, infinity, NaN) are classified. Sits between the operand-issue stage and the FPU result mux.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_round_norm.sv | 89 ++++++++
 rtl/fp_mul_pipe.sv | 165 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared floating-point definitions: operand/result classes,
//               flag bit positions, exponent bias and canonical quiet NaN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fp_pkg;

    // Operand class, also reused as the result class carried down the pipe.
    // As a result class, CLS_SNAN means "canonical NaN with invalid raised".
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_INF  = 3'd2,
        CLS_QNAN = 3'd3,
        CLS_SNAN = 3'd4
    } fp_class_e;

    // Flag vector layout: {invalid, overflow, underflow, inexact}
    localparam int FLAG_W         = 4;
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    // Exponent bias for an exponent field of exp_w bits
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in 128 bits
    function automatic logic [127:0] fp_canon_nan(input int exp_w, input int frac_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << frac_w;
        v = v | (128'd1 << (frac_w - 1));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_norm.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_norm
// Description : Combinational normalise / round-to-nearest-even / pack stage.
//               Takes a raw significand product, a biased exponent and the
//               pre-decided special class, returns the packed word and flags.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_in,
    input  logic [2*FRAC_W+1:0]       prod,
    input  fp_class_e                 cls,
    output logic [EXP_W+FRAC_W:0]     word,
    output logic [FLAG_W-1:0]         flags
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int E_W = EXP_W + 2;

    localparam logic signed [E_W-1:0] c_emax  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] c_ezero = '0;
    localparam logic [W-1:0]          c_nan   = W'(fp_canon_nan(EXP_W, FRAC_W));

    logic                    w_msb;
    logic [2*FRAC_W:0]       w_norm;
    logic [FRAC_W-1:0]       w_frac_pre;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_rnd_up;
    logic [FRAC_W:0]         w_frac_sum;
    logic [1:0]              w_inc;
    logic signed [E_W-1:0]   w_exp_fin;
    logic                    w_ovf;
    logic                    w_unf;

    // Product is in [1,4): shift by one when below 2 so the hidden bit drops out
    assign w_msb      = prod[2*FRAC_W+1];
    assign w_norm     = w_msb ? prod[2*FRAC_W:0] : {prod[2*FRAC_W-1:0], 1'b0};
    assign w_frac_pre = w_norm[2*FRAC_W:FRAC_W+1];
    assign w_guard    = w_norm[FRAC_W];
    assign w_sticky   = |w_norm[FRAC_W-1:0];

    // Nearest-even: round up above half, or exactly half with odd lsb
    assign w_rnd_up   = w_guard & (w_sticky | w_frac_pre[0]);
    assign w_frac_sum = {1'b0, w_frac_pre} + {{FRAC_W{1'b0}}, w_rnd_up};

    // Carry out of the fraction leaves it all-zero and bumps the exponent
    assign w_inc      = {1'b0, w_msb} + {1'b0, w_frac_sum[FRAC_W]};
    assign w_exp_fin  = exp_in + $signed({{EXP_W{1'b0}}, w_inc});
    assign w_ovf      = (w_exp_fin >= c_emax);
    assign w_unf      = (w_exp_fin <= c_ezero);

    // Special classes override the finite path; finite path checks range
    always_comb begin
        word  = '0;
        flags = '0;
        case (cls)
            CLS_SNAN: begin
                word                = c_nan;
                flags[FLAG_INVALID] = 1'b1;
            end
            CLS_QNAN: word = c_nan;
            CLS_INF:  word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            CLS_ZERO: word = {sign, {(W-1){1'b0}}};
            default: begin
                if (w_ovf) begin
                    word                  = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags[FLAG_OVERFLOW]  = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else if (w_unf) begin
                    word                  = {sign, {(W-1){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    word                  = {sign, w_exp_fin[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]};
                    flags[FLAG_INEXACT]   = w_guard | w_sticky;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : Three-stage, stall-capable IEEE-754 multiplier with
//               valid/ready handshake. S1 unpack/classify/exponent,
//               S2 significand product, S3 normalise/round/pack (output reg).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic [FLAG_W-1:0]         flags
);

    localparam int W   = 1 + EXP_W + FRAC_W;
    localparam int E_W = EXP_W + 2;
    localparam int S_W = FRAC_W + 1;
    localparam int P_W = 2 * FRAC_W + 2;

    localparam logic signed [E_W-1:0] c_bias = E_W'(fp_bias(EXP_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
        if (e == '0)        return CLS_ZERO;
        if (e != '1)        return CLS_NORM;
        if (f == '0)        return CLS_INF;
        if (f[FRAC_W-1])    return CLS_QNAN;
        return CLS_SNAN;
    endfunction

    // Handshake wires
    logic w_s1_load, w_s2_load, w_s3_load;

    // S1 combinational
    fp_class_e             w_cls_a, w_cls_b, w_cls_res;
    logic                  w_a_nan, w_b_nan, w_invalid;
    logic signed [E_W-1:0] w_exp_sum;

    // Pipeline registers
    logic                  r_s1_valid, r_s1_sign;
    logic signed [E_W-1:0] r_s1_exp;
    logic [S_W-1:0]        r_s1_sig_a, r_s1_sig_b;
    fp_class_e             r_s1_cls;

    logic                  r_s2_valid, r_s2_sign;
    logic signed [E_W-1:0] r_s2_exp;
    logic [P_W-1:0]        r_s2_prod;
    fp_class_e             r_s2_cls;

    logic [P_W-1:0]        w_prod;
    logic [W-1:0]          w_word;
    logic [FLAG_W-1:0]     w_flags;

    // Each stage refills when empty or when its successor takes its content
    assign w_s3_load = !out_valid || out_ready;
    assign w_s2_load = !r_s2_valid || w_s3_load;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_cls_a   = classify(a[W-2:FRAC_W], a[FRAC_W-1:0]);
    assign w_cls_b   = classify(b[W-2:FRAC_W], b[FRAC_W-1:0]);
    assign w_exp_sum = $signed({2'b00, a[W-2:FRAC_W]}) + $signed({2'b00, b[W-2:FRAC_W]}) - c_bias;

    // Resolve the result class by priority: NaN/invalid, infinity, zero, finite
    always_comb begin
        w_a_nan   = (w_cls_a == CLS_QNAN) || (w_cls_a == CLS_SNAN);
        w_b_nan   = (w_cls_b == CLS_QNAN) || (w_cls_b == CLS_SNAN);
        w_invalid = (w_cls_a == CLS_SNAN) || (w_cls_b == CLS_SNAN) ||
                    ((w_cls_a == CLS_INF) && (w_cls_b == CLS_ZERO)) ||
                    ((w_cls_a == CLS_ZERO) && (w_cls_b == CLS_INF));
        if (w_invalid)
            w_cls_res = CLS_SNAN;
        else if (w_a_nan || w_b_nan)
            w_cls_res = CLS_QNAN;
        else if ((w_cls_a == CLS_INF) || (w_cls_b == CLS_INF))
            w_cls_res = CLS_INF;
        else if ((w_cls_a == CLS_ZERO) || (w_cls_b == CLS_ZERO))
            w_cls_res = CLS_ZERO;
        else
            w_cls_res = CLS_NORM;
    end

    // S1: capture sign, biased exponent sum, significands and result class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_sig_a <= '0;
            r_s1_sig_b <= '0;
            r_s1_cls   <= CLS_ZERO;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= a[W-1] ^ b[W-1];
                r_s1_exp   <= w_exp_sum;
                r_s1_sig_a <= {1'b1, a[FRAC_W-1:0]};
                r_s1_sig_b <= {1'b1, b[FRAC_W-1:0]};
                r_s1_cls   <= w_cls_res;
            end
        end
    end

    assign w_prod = {{S_W{1'b0}}, r_s1_sig_a} * {{S_W{1'b0}}, r_s1_sig_b};

    // S2: full-width significand product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_prod  <= '0;
            r_s2_cls   <= CLS_ZERO;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_prod <= w_prod;
                r_s2_cls  <= r_s1_cls;
            end
        end
    end

    fp_round_norm #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_norm (
        .sign   (r_s2_sign),
        .exp_in (r_s2_exp),
        .prod   (r_s2_prod),
        .cls    (r_s2_cls),
        .word   (w_word),
        .flags  (w_flags)
    );

    // S3: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_s3_load) begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                result <= w_word;
                flags  <= w_flags;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Self-checking bench for fp_mul_pipe: vector table streamed
//               through a scoreboard, plus latency, backpressure, reset and
//               double-precision sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, result64;
    logic [3:0]  flags64;

    fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(11), .FRAC_W(52)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .flags(flags64)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    localparam int NV = 16;
    vec_t        vecs[NV];
    exp_t        exp_q[$];
    logic [31:0] cur_res;
    logic [3:0]  cur_flg;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on delivery
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready)
            exp_q.push_back('{cur_res, cur_flg});
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("result#%0d", n_out), 64'(result), 64'(e.res));
                check($sformatf("flags#%0d", n_out), 64'(flags), 64'(e.flg));
            end
        end
    end

    // Present one pair from posedge+1 until it is accepted
    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vres, input logic [3:0] vflg);
        int budget;
        budget   = 0;
        a        = va;
        b        = vb;
        cur_res  = vres;
        cur_flg  = vflg;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int budget;
        int seen;
        logic acc;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001};
        vecs[2]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[3]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[6]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vecs[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        vecs[9]  = '{32'hC0400000, 32'h40800000, 32'hC1400000, 4'b0000};
        vecs[10] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000};
        vecs[11] = '{32'h3FC00001, 32'h3FAAAAAA, 32'h40000000, 4'b0001};
        vecs[12] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000};
        vecs[13] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
        vecs[14] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};
        vecs[15] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        cur_res     = '0;
        cur_flg     = '0;
        in_valid64  = 1'b0;
        out_ready64 = 1'b1;
        a64         = '0;
        b64         = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted at edge N, out_valid after edge N+2
        a = vecs[0].a; b = vecs[0].b; cur_res = vecs[0].res; cur_flg = vecs[0].flg;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_after_N", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_after_N1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_after_N2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Vector table streamed back-to-back
        for (int i = 0; i < NV; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("table_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: only three pairs fit while the consumer stalls
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a = vecs[idx].a; b = vecs[idx].b; cur_res = vecs[idx].res; cur_flg = vecs[idx].flg;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_result_held", 64'(result), 64'(vecs[0].res));
        repeat (2) @(posedge clk);
        #1;
        check("bp_result_stable", 64'(result), 64'(vecs[0].res));
        check("bp_flags_stable", 64'(flags), 64'(vecs[0].flg));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("drain_valid%0d", k), 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        check("drain_empty", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int i = 4; i < 7; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
        check("rstmid_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rstmid_no_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Double-precision instance
        a64 = 64'h3FF8000000000000;
        b64 = 64'h4000000000000000;
        in_valid64 = 1'b1;
        @(negedge clk);
        check("dp_in_ready", 64'(in_ready64), 64'd1);
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        budget = 0;
        while (!out_valid64 && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        check("dp_out_valid", 64'(out_valid64), 64'd1);
        check("dp_result", result64, 64'h4008000000000000);
        check("dp_flags", 64'(flags64), 64'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
